hilo_mdu: RTL and testbench
===========================

# hilo_mdu

Execute-stage multiply/divide unit and HI/LO register file for the pipelined MIPS core. It consumes the 5-bit `alucontrol` code generated by the ALU decoder for the MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO group. It runs multi-cycle operations under a stall handshake and returns HI/LO read data to the E-stage result mux. The ALU keeps handling every other control code.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alucontrol`  in  5  E-stage control code, compared against the shared `*_CONTROL` defines
- `en`  in  1  E-stage instruction valid (not bubble); gates every action
- `flush`  in  1  E-stage flush; aborts any operation in progress
- `a`  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source)
- `b`  in  32  rt operand (divisor / multiplier)
- `stall`  out  1  hold F/D/E stages this cycle
- `hilo_out`  out  32  HI when `MFHI_CONTROL`, LO when `MFLO_CONTROL`, else 0

## Operation
- State machine states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset: HI=0, LO=0, state=IDLE, counter=0, `stall`=0, `hilo_out`=0.
- Start condition: IDLE and `en` and not `flush` and code is DIV/DIVU (or MULT/MULTU when the iterative multiplier is compiled in).
- On start:
  - For signed ops, latch |a| and |b|.
  - Record quotient/product sign = a[31]^b[31] and remainder sign = a[31].
  - Unsigned ops latch raw operands with both signs 0.
  - Counter=0. Next state: BUSY.
- BUSY: one radix-2 step per cycle.
  - Divide: restoring shift-subtract on a 64-bit {rem,quot} register.
  - Multiply: shift-add.
  - After 32 steps, go to DONE.
- DONE: apply two's-complement sign fixes, then write HI/LO at the clock edge. Next state: IDLE.
  - DONE ignores the start condition, even though the same instruction is still in E.
- Result mapping:
  - Divide: LO=quotient, HI=remainder.
  - Multiply: {HI,LO}=64-bit product.
- Divide by zero (b==0 at start, DIV or DIVU): no state-machine entry and no stall. HI=a and LO=32'hFFFFFFFF are written at the edge.
- MTHI/MTLO (IDLE, `en`): HI or LO takes the value of `a` at the edge. No stall.
- MFHI/MFLO: combinational read of the registered HI/LO. There is no bypass of a same-cycle write, because a writer always commits before a reader reaches E.
- `flush` in any state: go to IDLE. HI/LO are unchanged and `stall` drops the same cycle.
- `flush` has priority over start and over the DONE write.
- Unknown or other codes: no effect.

## Timing
- `stall` = start condition OR state==BUSY. It is combinational and deasserts in DONE.
- Divide issued in cycle C:
  - `stall` is high for cycles C..C+32 (33 cycles).
  - Cycle C+33 is DONE, with `stall`=0.
  - HI/LO are updated at the end of C+33.
  - The instruction leaves E at the same edge.
- A dependent MFHI/MFLO in E at cycle C+34 reads the new values.
- Consecutive divides: the second one starts from IDLE in cycle C+34. There are no gap cycles beyond DONE.
- Reset mid-operation: immediate IDLE, HI=LO=0, and `stall`=0 asynchronously.

## Configuration
- `HILO_ITER_MULT_EN` defined:
  - MULT/MULTU use the BUSY/DONE path, with 33 stall cycles and 34-cycle occupancy of E.
  - The shared datapath carries no `*` operator.
- `HILO_ITER_MULT_EN` undefined:
  - MULT/MULTU complete in one cycle: {HI,LO}=a*b (signed or unsigned) written at the edge, with no stall.
  - Divide behaviour is unchanged.

## Test plan
- DIV a=-7 (0xFFFFFFF9), b=2 -> `stall` high exactly 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; MFLO returns 0xFFFFFFFD.
- DIVU a=0xFFFFFFFF, b=0x10 -> LO=0x0FFFFFFF, HI=0x0000000F. Then DIV a=5, b=0 -> no stall, HI=5, LO=0xFFFFFFFF.
- MULT a=0xFFFFFFFF, b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE. Check with the macro both defined (33 stall cycles) and undefined (0 stall).
- MTHI a=0x12345678, next cycle MFHI -> `hilo_out`=0x12345678. MTLO a=0xA5A5A5A5, next cycle MFLO -> 0xA5A5A5A5, with HI unchanged.
- DIVU started with HI=LO=0x11111111 preloaded, `flush` on BUSY cycle 10 -> `stall` low that cycle, state IDLE, HI/LO still 0x11111111.
- `rst` pulsed asynchronously during BUSY cycle 20 -> `stall` low without waiting for a clock edge, HI=LO=0. A following DIV a=100, b=7 -> LO=14, HI=2.

Source files
------------

// File: rtl/hilo_mdu.sv
// hilo_mdu: E-stage multiply/divide unit with the HI/LO register pair.
// Define HILO_ITER_MULT_EN to run MULT/MULTU on the iterative shift-add path instead of a one-cycle multiplier.

`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b10000
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b10001
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'b10010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'b10011
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'b10100
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'b10101
`endif
`ifndef MFHI_CONTROL
`define MFHI_CONTROL  5'b10110
`endif
`ifndef MFLO_CONTROL
`define MFLO_CONTROL  5'b10111
`endif

module hilo_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alucontrol,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic [31:0] hilo_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opB_q, opB_d;
  logic        negQ_q, negQ_d;
  logic        negR_q, negR_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic isDivCode, isMultCode, isSignedCode;
  logic idleIssue, divZero, startOp;
  logic [31:0] absA, absB;
  logic [32:0] remShift;
  logic [33:0] remDiff;
  logic [63:0] divStep;
  logic [31:0] quotFix, remFix;

  assign isDivCode    = (alucontrol == `DIV_CONTROL) || (alucontrol == `DIVU_CONTROL);
  assign isMultCode   = (alucontrol == `MULT_CONTROL) || (alucontrol == `MULTU_CONTROL);
  assign isSignedCode = (alucontrol == `DIV_CONTROL) || (alucontrol == `MULT_CONTROL);

  // rst is folded in so stall collapses immediately on an asynchronous reset.
  assign idleIssue = (state_q == IDLE) && en && !flush && !rst;
  assign divZero   = idleIssue && isDivCode && (b == 32'd0);

`ifdef HILO_ITER_MULT_EN
  logic        isDiv_q, isDiv_d;
  logic [32:0] addSum;
  logic [63:0] mulStep;
  logic [63:0] prodFix;

  assign startOp = idleIssue && ((isDivCode && (b != 32'd0)) || isMultCode);
  assign addSum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opB_q} : 33'd0);
  assign mulStep = {addSum, acc_q[31:1]};
  assign prodFix = negQ_q ? -acc_q : acc_q;
`else
  logic [63:0] mulA, mulB, product;

  assign startOp = idleIssue && isDivCode && (b != 32'd0);
  assign mulA    = {{32{isSignedCode & a[31]}}, a};
  assign mulB    = {{32{isSignedCode & b[31]}}, b};
  assign product = mulA * mulB;
`endif

  assign absA = (isSignedCode && a[31]) ? -a : a;
  assign absB = (isSignedCode && b[31]) ? -b : b;

  // Restoring divide step: shift {rem,quot} left and subtract the divisor when it fits.
  assign remShift = acc_q[63:31];
  assign remDiff  = {1'b0, remShift} - {2'b00, opB_q};
  assign divStep  = remDiff[33] ? {acc_q[62:0], 1'b0}
                                : {remDiff[31:0], acc_q[30:0], 1'b1};

  assign quotFix = negQ_q ? -acc_q[31:0]  : acc_q[31:0];
  assign remFix  = negR_q ? -acc_q[63:32] : acc_q[63:32];

  assign stall = startOp || ((state_q == BUSY) && !flush);

  always_comb begin
    hilo_out = 32'd0;
    if (alucontrol == `MFHI_CONTROL)      hilo_out = hi_q;
    else if (alucontrol == `MFLO_CONTROL) hilo_out = lo_q;
  end

  // Next-state logic; flush wins over both a new start and the DONE write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opB_d   = opB_q;
    negQ_d  = negQ_q;
    negR_d  = negR_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef HILO_ITER_MULT_EN
    isDiv_d = isDiv_q;
`endif
    case (state_q)
      IDLE: begin
        if (startOp) begin
          state_d = BUSY;
          cnt_d   = 5'd0;
          negQ_d  = isSignedCode & (a[31] ^ b[31]);
          negR_d  = isSignedCode & a[31];
`ifdef HILO_ITER_MULT_EN
          isDiv_d = isDivCode;
          acc_d   = {32'd0, isDivCode ? absA : absB};
          opB_d   = isDivCode ? absB : absA;
`else
          acc_d   = {32'd0, absA};
          opB_d   = absB;
`endif
        end else if (divZero) begin
          hi_d = a;
          lo_d = 32'hFFFF_FFFF;
        end else if (idleIssue) begin
          if (alucontrol == `MTHI_CONTROL) hi_d = a;
          if (alucontrol == `MTLO_CONTROL) lo_d = a;
`ifndef HILO_ITER_MULT_EN
          if (isMultCode) begin
            hi_d = product[63:32];
            lo_d = product[31:0];
          end
`endif
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
`ifdef HILO_ITER_MULT_EN
          acc_d = isDiv_q ? divStep : mulStep;
`else
          acc_d = divStep;
`endif
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
`ifdef HILO_ITER_MULT_EN
          if (isDiv_q) begin
            hi_d = remFix;
            lo_d = quotFix;
          end else begin
            hi_d = prodFix[63:32];
            lo_d = prodFix[31:0];
          end
`else
          hi_d = remFix;
          lo_d = quotFix;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      opB_q   <= 32'd0;
      negQ_q  <= 1'b0;
      negR_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opB_q   <= opB_d;
      negQ_q  <= negQ_d;
      negR_q  <= negR_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef HILO_ITER_MULT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) isDiv_q <= 1'b0;
    else     isDiv_q <= isDiv_d;
  end
`endif

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: expected HI/LO/stall pushed on issue, popped after MFHI/MFLO readback.
// Expected multiply stall depends on HILO_ITER_MULT_EN.

`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b10000
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b10001
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'b10010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'b10011
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'b10100
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'b10101
`endif
`ifndef MFHI_CONTROL
`define MFHI_CONTROL  5'b10110
`endif
`ifndef MFLO_CONTROL
`define MFLO_CONTROL  5'b10111
`endif

module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  alucontrol = 5'd0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        stall;
  logic [31:0] hilo_out;

`ifdef HILO_ITER_MULT_EN
  localparam int MUL_STALL = 33;
`else
  localparam int MUL_STALL = 0;
`endif

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          nStall;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  hilo_mdu dut (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .en(en), .flush(flush),
    .a(a), .b(b), .stall(stall), .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  task automatic runOp(input logic [4:0] code, input logic [31:0] opA, input logic [31:0] opB,
                       output int nStall);
    @(negedge clk);
    alucontrol = code; en = 1'b1; a = opA; b = opB;
    nStall = 0;
    #1;
    while (stall && nStall < 100) begin
      nStall++;
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    en = 1'b0; alucontrol = 5'd0;
  endtask

  task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk);
    en = 1'b1; alucontrol = `MFHI_CONTROL;
    #1 hi = hilo_out;
    alucontrol = `MFLO_CONTROL;
    #1 lo = hilo_out;
    en = 1'b0; alucontrol = 5'd0;
  endtask

  task automatic issueAndCheck(input string name, input logic [4:0] code,
                               input logic [31:0] opA, input logic [31:0] opB,
                               input logic [31:0] expHi, input logic [31:0] expLo, input int expStall);
    exp_t e;
    exp_t got;
    int n;
    logic [31:0] hi, lo;
    e.name = name; e.hi = expHi; e.lo = expLo; e.nStall = expStall;
    sb.push_back(e);
    runOp(code, opA, opB, n);
    readHiLo(hi, lo);
    got = sb.pop_front();
    total++;
    if (n !== got.nStall) begin
      bad++;
      $display("[TB] FAIL %s stall: got %0d cycles, want %0d", got.name, n, got.nStall);
    end
    total++;
    if (hi !== got.hi) begin
      bad++;
      $display("[TB] FAIL %s hi: got %h, want %h", got.name, hi, got.hi);
    end
    total++;
    if (lo !== got.lo) begin
      bad++;
      $display("[TB] FAIL %s lo: got %h, want %h", got.name, lo, got.lo);
    end
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset stall: got %b, want 0", stall);
    end
    readHiLo(hi, lo);
    total++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset hilo: got %h/%h, want 0/0", hi, lo);
    end
  endtask

  task automatic test_divide;
    issueAndCheck("div_neg7_2", `DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    issueAndCheck("divu_max_16", `DIVU_CONTROL, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 33);
    issueAndCheck("div_by_zero", `DIV_CONTROL, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
    issueAndCheck("divu_by_zero", `DIVU_CONTROL, 32'h8000_0001, 32'd0, 32'h8000_0001, 32'hFFFF_FFFF, 0);
    issueAndCheck("div_min_pos", `DIV_CONTROL, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 32'hD555_5556, 33);
  endtask

  task automatic test_random_div;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] x, y, q, r;
      int sx, sy;
      x = $urandom;
      y = $urandom >> $urandom_range(0, 28);
      if (y == 32'd0) y = 32'd9;
      if (i % 2 == 0) begin
        q = x / y; r = x % y;
        issueAndCheck("divu_rand", `DIVU_CONTROL, x, y, r, q, 33);
      end else begin
        if (y == 32'hFFFF_FFFF) y = 32'd3;
        sx = x; sy = y;
        q = sx / sy; r = sx % sy;
        issueAndCheck("div_rand", `DIV_CONTROL, x, y, r, q, 33);
      end
    end
  endtask

  task automatic test_mult;
    issueAndCheck("mult_neg1_2", `MULT_CONTROL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALL);
    issueAndCheck("multu_max_2", `MULTU_CONTROL, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MUL_STALL);
    issueAndCheck("mult_min_min", `MULT_CONTROL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_STALL);
    issueAndCheck("mult_neg_pos", `MULT_CONTROL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_STALL);
  endtask

  task automatic test_mthi_mtlo;
    int n;
    logic [31:0] hi, lo;
    runOp(`MTHI_CONTROL, 32'h1234_5678, 32'd0, n);
    readHiLo(hi, lo);
    total++;
    if (hi !== 32'h1234_5678 || n !== 0) begin
      bad++;
      $display("[TB] FAIL mthi: got hi=%h stall=%0d, want 12345678/0", hi, n);
    end
    runOp(`MTLO_CONTROL, 32'hA5A5_A5A5, 32'd0, n);
    readHiLo(hi, lo);
    total++;
    if (lo !== 32'hA5A5_A5A5 || hi !== 32'h1234_5678) begin
      bad++;
      $display("[TB] FAIL mtlo: got %h/%h, want 12345678/a5a5a5a5", hi, lo);
    end
  endtask

  task automatic test_flush;
    int n;
    logic [31:0] hi, lo;
    runOp(`MTHI_CONTROL, 32'h1111_1111, 32'd0, n);
    runOp(`MTLO_CONTROL, 32'h1111_1111, 32'd0, n);
    @(negedge clk);
    alucontrol = `DIVU_CONTROL; en = 1'b1; a = 32'd1000; b = 32'd3;
    n = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (stall) n++;
      @(negedge clk);
      #1;
    end
    flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || n !== 10) begin
      bad++;
      $display("[TB] FAIL flush_stall: got stall=%b pre=%0d, want 0/10", stall, n);
    end
    @(posedge clk);
    #1;
    flush = 1'b0; en = 1'b0; alucontrol = 5'd0;
    readHiLo(hi, lo);
    total++;
    if (hi !== 32'h1111_1111 || lo !== 32'h1111_1111) begin
      bad++;
      $display("[TB] FAIL flush_hilo: got %h/%h, want 11111111/11111111", hi, lo);
    end
    issueAndCheck("div_after_flush", `DIVU_CONTROL, 32'd100, 32'd7, 32'd2, 32'd14, 33);
  endtask

  task automatic test_reset_mid;
    int n;
    logic [31:0] hi, lo;
    runOp(`MTHI_CONTROL, 32'h2222_2222, 32'd0, n);
    runOp(`MTLO_CONTROL, 32'h3333_3333, 32'd0, n);
    @(negedge clk);
    alucontrol = `DIV_CONTROL; en = 1'b1; a = 32'd1000; b = 32'd3;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy20_stall: got %b, want 1", stall);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_rst_stall: got %b, want 0", stall);
    end
    en = 1'b0; alucontrol = 5'd0;
    #1 rst = 1'b0;
    readHiLo(hi, lo);
    total++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("[TB] FAIL async_rst_hilo: got %h/%h, want 0/0", hi, lo);
    end
    issueAndCheck("div_after_rst", `DIV_CONTROL, 32'd100, 32'd7, 32'd2, 32'd14, 33);
  endtask

  task automatic test_back_to_back;
    issueAndCheck("b2b_first", `DIV_CONTROL, 32'd77, 32'hFFFF_FFF6, 32'd7, 32'hFFFF_FFF9, 33);
    issueAndCheck("b2b_second", `DIVU_CONTROL, 32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_BEEF, 32'h0000_DEAD, 33);
  endtask

  // Watchdog so a wedged handshake still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_reset;
    test_divide;
    test_random_div;
    test_mult;
    test_mthi_mtlo;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
